// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS-wide PWM generator with one shared prescaler and period counter,
// edge/center alignment and double-buffered settings. Define PWM_DEADTIME_EN for dead-band.
module pwm_multi #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int PRESC_W  = 8,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [PRESC_W-1:0]  prescale,
   input  logic [WIDTH-1:0]    period,
   input  logic                center_mode,
   input  logic                duty_wr,
   input  logic [SEL_W-1:0]    duty_sel,
   input  logic [WIDTH-1:0]    duty_data,
   input  logic [3:0]          dead_time,
   output logic [CHANNELS-1:0] pwm_out,
   output logic [CHANNELS-1:0] pwm_out_n,
   output logic                period_tick
);

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic                dir_q, dir_d;
   logic [WIDTH-1:0]    shadow_q   [CHANNELS];
   logic [WIDTH-1:0]    shadow_d   [CHANNELS];
   logic [WIDTH-1:0]    duty_act_q [CHANNELS];
   logic [WIDTH-1:0]    duty_act_d [CHANNELS];
   logic [WIDTH-1:0]    period_act_q, period_act_d;
   logic                mode_act_q, mode_act_d;
   logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;
   logic [CHANNELS-1:0] pwm_out_n_q, pwm_out_n_d;
   logic                period_tick_q, period_tick_d;
   logic                tick;
   logic                boundary;
   logic                reload;
   logic [CHANNELS-1:0] cmp;

   // NOTE: every signal driven in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      boundary = 1'b0;
      tick     = (presc_q == prescale);
      if (!en) begin
         presc_d = '0;
         cnt_d   = '0;
         dir_d   = 1'b0;
      end else if (!tick) begin
         presc_d = presc_q + PRESC_W'(1);
      end else begin
         presc_d = '0;
         if (!mode_act_q) begin
            if (cnt_q >= period_act_q) begin
               cnt_d    = '0;
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else if (period_act_q == '0) begin
            cnt_d    = '0;
            dir_d    = 1'b0;
            boundary = 1'b1;
         end else if (!dir_q && (cnt_q < period_act_q)) begin
            cnt_d = cnt_q + WIDTH'(1);
         end else begin
            // Top of the triangle and the down slope; reaching 0 closes the period.
            cnt_d    = cnt_q - WIDTH'(1);
            boundary = (cnt_q == WIDTH'(1));
            dir_d    = ~boundary;
         end
      end
   end

   // While stopped, the active set tracks the shadows so a restart uses the latest values.
   always_comb begin
      reload       = ~en | boundary;
      period_act_d = reload ? period : period_act_q;
      mode_act_d   = reload ? center_mode : mode_act_q;
      for (int i = 0; i < CHANNELS; i++) begin
         shadow_d[i]   = shadow_q[i];
         duty_act_d[i] = reload ? shadow_q[i] : duty_act_q[i];
      end
      if (duty_wr && (int'(duty_sel) < CHANNELS)) begin
         shadow_d[duty_sel] = duty_data;
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         cmp[i] = (cnt_q < duty_act_q[i]);
      end
   end

`ifdef PWM_DEADTIME_EN
   // Each channel remembers which output should be high and for how long that has held.
   logic [1:0] phase_q [CHANNELS];
   logic [1:0] phase_d [CHANNELS];
   logic [3:0] run_q   [CHANNELS];
   logic [3:0] run_d   [CHANNELS];

   always_comb begin
      period_tick_d = boundary;
      pwm_out_d     = '0;
      pwm_out_n_d   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         phase_d[i] = {en & cmp[i], en & ~cmp[i]};
         if (phase_d[i] != phase_q[i]) begin
            run_d[i] = '0;
         end else if (run_q[i] != 4'hF) begin
            run_d[i] = run_q[i] + 4'd1;
         end else begin
            run_d[i] = run_q[i];
         end
         pwm_out_d[i]   = phase_d[i][1] & (run_d[i] >= dead_time);
         pwm_out_n_d[i] = phase_d[i][0] & (run_d[i] >= dead_time);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            phase_q[i] <= '0;
            run_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            phase_q[i] <= phase_d[i];
            run_q[i]   <= run_d[i];
         end
      end
   end
`else
   logic unused_dead_time;
   assign unused_dead_time = ^dead_time;

   always_comb begin
      period_tick_d = boundary;
      pwm_out_d     = {CHANNELS{en}} & cmp;
      pwm_out_n_d   = {CHANNELS{en}} & ~cmp;
   end
`endif

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q       <= '0;
         cnt_q         <= '0;
         dir_q         <= 1'b0;
         period_act_q  <= '0;
         mode_act_q    <= 1'b0;
         pwm_out_q     <= '0;
         pwm_out_n_q   <= '0;
         period_tick_q <= 1'b0;
         // NOTE: duty registers are a handful of flops, not RAM, so they are reset with the rest.
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i]   <= '0;
            duty_act_q[i] <= '0;
         end
      end else begin
         presc_q       <= presc_d;
         cnt_q         <= cnt_d;
         dir_q         <= dir_d;
         period_act_q  <= period_act_d;
         mode_act_q    <= mode_act_d;
         pwm_out_q     <= pwm_out_d;
         pwm_out_n_q   <= pwm_out_n_d;
         period_tick_q <= period_tick_d;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i]   <= shadow_d[i];
            duty_act_q[i] <= duty_act_d[i];
         end
      end
   end

   assign pwm_out     = pwm_out_q;
   assign pwm_out_n   = pwm_out_n_q;
   assign period_tick = period_tick_q;

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised multi-channel PWM generator; successor to the single-channel, fixed-width 7-bit duty PWM used in the tt_um top level.
- One shared prescaler and period counter drive CHANNELS compare outputs, each with a complementary output.
- Duty, period and mode writes are double-buffered and take effect only at a period boundary, so no output glitches.
- Edge-aligned or center-aligned counting is selected at runtime; sits between the tt_um wrapper pins and a simple register-write interface.

Parameters:
- WIDTH, 8, width of the period counter, period and duty values.
- CHANNELS, 4, number of independent PWM channels (1..8).
- PRESC_W, 8, width of the clock prescaler.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- prescale  input  PRESC_W  counter advances once every prescale+1 clocks.
- period  input  WIDTH  period value P; sampled into period_act at each boundary.
- center_mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled at each boundary.
- duty_wr  input  1  single-cycle write strobe.
- duty_sel  input  max(1,$clog2(CHANNELS))  channel index for the write.
- duty_data  input  WIDTH  duty value for the write.
- dead_time  input  4  dead-band length in clocks; used only with PWM_DEADTIME_EN.
- pwm_out  output  CHANNELS  PWM outputs, registered.
- pwm_out_n  output  CHANNELS  complementary outputs, registered.
- period_tick  output  1  one-clock pulse on each period boundary.

Behaviour:
- Reset (async, rst_n=0):
  - prescaler, cnt, dir, all shadow and active duties, period_act and mode_act clear to 0.
  - pwm_out, pwm_out_n and period_tick are 0.
- Prescaler: counts 0..prescale; tick = (presc_cnt==prescale). prescale=0 gives a tick every clock.
- Edge mode: on tick, cnt increments; when cnt==period_act, cnt wraps to 0 instead (boundary). Period length = (P+1)*(prescale+1) clocks.
- Center mode: on tick, cnt counts up 0..P, then down P-1..0.
  - dir flips to down at cnt==P and back to up on reaching 0.
  - Boundary = the tick that moves cnt from 1 down to 0 (or to 0 when P=0).
  - Period length = 2P ticks; with P=0 every tick is a boundary.
- Writes: duty_wr=1 stores duty_data into shadow[duty_sel]. A duty_sel value of CHANNELS or more is ignored. Writes never affect the active duty mid-period.
- Boundary actions, all in the same clock:
  - duty_act[i] <= shadow[i] for every channel;
  - period_act <= period and mode_act <= center_mode;
  - period_tick is asserted on the following clock for exactly one cycle.
- A write coinciding with the boundary tick lands in the shadow register and is loaded at the next boundary, not the current one.
- Compare: pwm_out[i] <= en & (cnt < duty_act[i]), registered, so outputs lag cnt by one clock.
  - duty=0 gives a constant 0; duty>P gives a constant 1 (100%) for the whole period.
- pwm_out_n[i] <= en & ~(cnt < duty_act[i]) when PWM_DEADTIME_EN is not defined.
- en=0:
  - prescaler, cnt and dir are held at 0;
  - active values reload from the shadow registers, period and center_mode every clock;
  - all outputs are 0 and period_tick is 0.
  - On en rising, counting starts at cnt=0 with the latest values; the first boundary occurs after one full period.
- A mode change mid-period is deferred to the boundary; the counter never jumps.

Optional Feature:
- PWM_DEADTIME_EN defined: each channel gets a dead-band unit.
  - The rising edge of pwm_out[i] and of pwm_out_n[i] is delayed by dead_time clocks after the raw compare changes; falling edges are immediate.
  - pwm_out[i] and pwm_out_n[i] are never both 1.
  - dead_time=0 behaves identically to the undefined case.
  - If a pulse is shorter than dead_time, that output stays 0 for the pulse.
- PWM_DEADTIME_EN undefined: dead_time is ignored and pwm_out_n is the plain registered complement gated by en, as above.

Test Plan:
- Edge mode, WIDTH=8, CHANNELS=4, prescale=0, P=9, duty ch0=3, ch1=0, ch2=10, en=1 -> ch0 high 3 of every 10 clocks; ch1 always 0; ch2 always 1; period_tick every 10 clocks.
- Write ch0 duty 3 -> 7 mid-period -> pulse width stays 3 until the boundary after the write, then 7; no truncated or extra pulses.
- prescale=3, P=4, duty=2 -> period 20 clocks; pwm_out high for 8 consecutive clocks.
- Center mode, P=8, duty=4, prescale=0 -> period 16 clocks; high pulse is symmetric about cnt=0; period_tick at each 1->0 transition.
- Reset asserted mid-period (rst_n low for 1 clock, asynchronous edge) -> all outputs 0 immediately; after release, counting restarts from 0 with duties 0.
- With PWM_DEADTIME_EN, dead_time=2, P=9, duty=5 -> pwm_out high for 3 clocks, pwm_out_n high for 3 clocks, 2-clock all-low gap at each transition; the two outputs never overlap.
